ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch controller: consumes the PC value, reads instruction memory through a req/ack handshake and buffers fetched words in a small queue toward the decoder.
- Drives the PC block's control inputs back: a one-cycle increment pulse after each fetch, or a load pulse on a branch redirect.
- Sits between the PC block, instruction memory and the decode stage of the 16-bit core.

Parameters:
- QDEPTH, 2, instruction queue entries (power of two, >=2)
- W, `WORD_SIZE (16), address and instruction width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- pc_value  in  W  current PC value from PC block
- pc_data  out  W  data to PC block (1 on increment, target on redirect)
- pc_offset  out  1  PC add-pulse
- pc_load  out  1  PC load-pulse
- mem_req  out  1  memory read request
- mem_addr  out  W  read address, stable while mem_req=1
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  W  read data
- instr_valid  out  1  queue head valid
- instr  out  W  queue head instruction
- instr_pc  out  W  address of queue head instruction
- instr_ready  in  1  decoder accepts head
- redirect  in  1  branch/jump taken, flush
- redirect_addr  in  W  new PC

Behaviour:
- Reset: synchronous, active-high, highest priority. All outputs 0; queue empty; FSM=IDLE. An outstanding mem_req is dropped immediately; memory shares rst.
- FSM states: IDLE, REQ, ADV, DRAIN.
- IDLE: if count<QDEPTH and !redirect, register mem_addr<=pc_value, mem_req<=1, go to REQ.
- REQ: mem_req and mem_addr held until mem_ack. On mem_ack:
  - push {mem_addr, mem_rdata}, mem_req<=0;
  - next cycle pc_offset=1 and pc_data=1 for exactly one cycle;
  - go to ADV.
- ADV: one settle cycle for the PC; go to IDLE.
- Redirect, which has priority over fetch and push:
  - In every state: flush queue (count<=0) and pulse pc_load=1 with pc_data=redirect_addr next cycle for one cycle. pc_offset is never asserted in that same cycle.
  - IDLE or ADV: go to ADV.
  - REQ with mem_ack same cycle: data discarded, go to ADV.
  - REQ without mem_ack: go to DRAIN; mem_req stays high (req is never withdrawn before ack).
- DRAIN: wait for mem_ack, discard data, drop mem_req, go to ADV. A repeated redirect in DRAIN re-pulses pc_load with the newest address and stays in DRAIN.
- Latency with zero-wait memory: IDLE→REQ (ack same cycle)→instr_valid next cycle. Steady-state throughput is one instruction per 3 cycles.
- Queue:
  - FIFO, pop when instr_valid && instr_ready; simultaneous push+pop allowed, count unchanged.
  - Issue is gated, so push never occurs when full.
  - instr/instr_pc hold their value while !instr_ready.
  - A pop in the same cycle as redirect counts as consumed; the queue is empty afterwards.
- Pointers wrap modulo QDEPTH. Address arithmetic is W bits, wrapping 0xFFFF→0x0000 in the PC block.

Optional Feature:
- IFETCH_STATS_EN defined: adds outputs stat_fetch (16b, count of pushed instructions) and stat_discard (16b, count of responses dropped by redirect). Both saturate at 0xFFFF and clear on rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared defines include: WORD_SIZE, TIMER_SIZE, FSM state encodings (IF_IDLE, IF_REQ, IF_ADV, IF_DRAIN).
- Sub-module ifetch_queue (parameterised FIFO: push, pop, flush, count, head data) instantiated once.

Test Plan:
- Reset, pc_value=0x0010, zero-wait memory returning 0xA5A5 → mem_req cycle 1 with addr 0x0010; instr_valid=1, instr=0xA5A5, instr_pc=0x0010 cycle 3; pc_offset single pulse with pc_data=1.
- instr_ready=0, 4 fetch opportunities → exactly QDEPTH=2 entries, mem_req stays 0 afterwards; raise ready → entries delivered in order 0x0010, 0x0011.
- Redirect to 0x0200 while mem_ack held low 3 cycles → DRAIN entered, mem_req held until ack, data discarded, one pc_load pulse with pc_data=0x0200, next instr_pc=0x0200.
- Redirect with queue full and simultaneous pop → count 0, instr_valid=0 next cycle, no pc_offset in the pc_load cycle.
- rst asserted mid-REQ → next cycle mem_req=0, all outputs 0, FSM IDLE.
- IFETCH_STATS_EN: 3 fetches plus 1 discarded response → stat_fetch=3, stat_discard=1.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit of the 16-bit core.
// Word/timer sizes, fetch FSM encodings and a saturating-increment helper.
// Optional statistics counters in ifetch_unit are enabled with IFETCH_STATS_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef TIMER_SIZE
`define TIMER_SIZE 16
`endif

package ifetch_pkg;

   // Fetch controller states, also exposed on the state_dbg port.
   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_REQ   = 2'd1,
      IF_ADV   = 2'd2,
      IF_DRAIN = 2'd3
   } if_state_t;

   localparam int STAT_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Small FIFO holding fetched {address, instruction} pairs for the decoder.
// Flush empties it in one cycle and wins over push/pop; pointers wrap
// naturally because DEPTH is a power of two.
module ifetch_queue #(
   parameter int DEPTH = 2,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_addr,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head_valid,
   output logic [W-1:0]             head_addr,
   output logic [W-1:0]             head_data
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  addr_mem [DEPTH];
   logic [W-1:0]  data_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Storage, pointers and occupancy; flush discards everything incl. a same-cycle pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem[i] <= '0;
            data_mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_valid = (count != '0);
   assign head_addr  = addr_mem[rd_ptr];
   assign head_data  = data_mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch controller: issues one memory read per free queue slot,
// buffers results toward decode and pulses the PC block (increment after a
// fetch, load on redirect). Optional counters stat_fetch/stat_discard exist
// only when IFETCH_STATS_EN is defined.
// Handshakes: mem_req rises with mem_addr and both hold until a cycle with
// mem_ack=1, which completes the read; a request is never withdrawn early.
// Decode side: instr is consumed in a cycle with instr_valid && instr_ready;
// instr/instr_pc hold while instr_ready is low.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int QDEPTH = 2,
   parameter int W      = `WORD_SIZE
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] pc_value,
   output logic [W-1:0] pc_data,
   output logic         pc_offset,
   output logic         pc_load,
   output logic         mem_req,
   output logic [W-1:0] mem_addr,
   input  logic         mem_ack,
   input  logic [W-1:0] mem_rdata,
   output logic         instr_valid,
   output logic [W-1:0] instr,
   output logic [W-1:0] instr_pc,
   input  logic         instr_ready,
   input  logic         redirect,
   input  logic [W-1:0] redirect_addr,
   output logic [1:0]   state_dbg
`ifdef IFETCH_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_fetch,
   output logic [STAT_W-1:0] stat_discard
`endif
);

   localparam int CW = $clog2(QDEPTH) + 1;

   if_state_t     state, state_nxt;
   logic          req_nxt;
   logic [W-1:0]  addr_nxt;
   logic          offset_nxt;
   logic          load_nxt;
   logic [W-1:0]  data_nxt;
   logic          q_push;
   logic          q_pop;
   logic          q_flush;
   logic [CW-1:0] q_count;

   assign q_pop     = instr_valid && instr_ready;
   assign state_dbg = state;

   ifetch_queue #(.DEPTH(QDEPTH), .W(W)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (q_push),
      .push_addr  (mem_addr),
      .push_data  (mem_rdata),
      .pop        (q_pop),
      .flush      (q_flush),
      .count      (q_count),
      .head_valid (instr_valid),
      .head_addr  (instr_pc),
      .head_data  (instr)
   );

   // Next state, request registers and PC pulses; redirect beats fetch/push.
   always_comb begin
      state_nxt  = state;
      req_nxt    = mem_req;
      addr_nxt   = mem_addr;
      offset_nxt = 1'b0;
      load_nxt   = 1'b0;
      data_nxt   = '0;
      q_push     = 1'b0;
      q_flush    = 1'b0;
      if (redirect) begin
         load_nxt = 1'b1;
         data_nxt = redirect_addr;
         q_flush  = 1'b1;
      end
      case (state)
         IF_IDLE: begin
            if (redirect) begin
               state_nxt = IF_ADV;
            end else if (q_count < CW'(QDEPTH)) begin
               req_nxt   = 1'b1;
               addr_nxt  = pc_value;
               state_nxt = IF_REQ;
            end
         end
         IF_REQ: begin
            if (mem_ack) begin
               req_nxt   = 1'b0;
               state_nxt = IF_ADV;
               if (!redirect) begin
                  q_push     = 1'b1;
                  offset_nxt = 1'b1;
                  data_nxt   = W'(1);
               end
            end else if (redirect) begin
               state_nxt = IF_DRAIN;
            end
         end
         IF_ADV: begin
            state_nxt = redirect ? IF_ADV : IF_IDLE;
         end
         IF_DRAIN: begin
            // Stale response: throw it away once it finally arrives.
            if (mem_ack) begin
               req_nxt   = 1'b0;
               state_nxt = IF_ADV;
            end
         end
         default: begin
            state_nxt = IF_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset drops any outstanding request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IF_IDLE;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         pc_offset <= 1'b0;
         pc_load   <= 1'b0;
         pc_data   <= '0;
      end else begin
         state     <= state_nxt;
         mem_req   <= req_nxt;
         mem_addr  <= addr_nxt;
         pc_offset <= offset_nxt;
         pc_load   <= load_nxt;
         pc_data   <= data_nxt;
      end
   end

`ifdef IFETCH_STATS_EN
   logic discard;
   assign discard = mem_req && mem_ack &&
                    (((state == IF_REQ) && redirect) || (state == IF_DRAIN));

   // Saturating counts of pushed instructions and responses dropped by redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetch   <= '0;
         stat_discard <= '0;
      end else begin
         if (q_push)  stat_fetch   <= sat_inc(stat_fetch);
         if (discard) stat_discard <= sat_inc(stat_discard);
      end
   end
`else
   // Statistics counters not built.
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with a PC-block model, a simple memory
// whose ack can be stalled, and a scoreboard of expected {pc, instr} pairs.
`timescale 1ns/1ps
module tb_ifetch_unit;
   import ifetch_pkg::*;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] pc_value;
   logic [W-1:0] pc_data;
   logic         pc_offset;
   logic         pc_load;
   logic         mem_req;
   logic [W-1:0] mem_addr;
   logic         mem_ack;
   logic [W-1:0] mem_rdata;
   logic         instr_valid;
   logic [W-1:0] instr;
   logic [W-1:0] instr_pc;
   logic         instr_ready;
   logic         redirect;
   logic [W-1:0] redirect_addr;
   logic [1:0]   state_dbg;
`ifdef IFETCH_STATS_EN
   logic [15:0]  stat_fetch;
   logic [15:0]  stat_discard;
`endif

   logic         ack_en;
   logic [W-1:0] pc_init;
   logic [31:0]  exp_q[$];
   logic [W-1:0] exp_pc;
   bit           drain_pend;
   int           fetch_cnt;
   int           disc_cnt;
   int           n_tests = 0;
   int           n_fail  = 0;

   ifetch_unit #(.QDEPTH(2), .W(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_value      (pc_value),
      .pc_data       (pc_data),
      .pc_offset     (pc_offset),
      .pc_load       (pc_load),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_ready   (instr_ready),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .state_dbg     (state_dbg)
`ifdef IFETCH_STATS_EN
      ,
      .stat_fetch    (stat_fetch),
      .stat_discard  (stat_discard)
`endif
   );

   // clock / reset environment
   always #5 clk = ~clk;

   // zero-wait memory unless stalled; data is a fixed function of the address
   assign mem_ack   = mem_req && ack_en;
   assign mem_rdata = mem_addr ^ 16'hA5B5;

   // PC block model
   always @(posedge clk) begin
      if (rst)            pc_value <= pc_init;
      else if (pc_load)   pc_value <= pc_data;
      else if (pc_offset) pc_value <= pc_value + pc_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string tag);
      int ok = 0;
      for (int i = 0; i < 30; i++) begin
         if (mem_req) begin ok = 1; break; end
         step();
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      int ok = 0;
      for (int i = 0; i < 30; i++) begin
         if (instr_valid) begin ok = 1; break; end
         step();
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   // scoreboard: expectation pushed when memory answers, popped on decoder accept
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst) begin
         exp_q.delete();
         exp_pc     = pc_init;
         drain_pend = 1'b0;
         fetch_cnt  = 0;
         disc_cnt   = 0;
      end else begin
         chk("pulse_excl", 32'(pc_load & pc_offset), 32'd0);
         if (instr_valid && instr_ready) begin
            chk("pop_has_exp", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("pop_pc", 32'(instr_pc), 32'(e[31:16]));
               chk("pop_instr", 32'(instr), 32'(e[15:0]));
            end
         end
         if (redirect) exp_q.delete();
         if (mem_req && mem_ack) begin
            if (redirect || drain_pend) begin
               disc_cnt++;
               drain_pend = 1'b0;
            end else begin
               chk("mem_addr", 32'(mem_addr), 32'(exp_pc));
               exp_q.push_back({exp_pc, 16'(exp_pc ^ 16'hA5B5)});
               exp_pc = exp_pc + 16'd1;
               fetch_cnt++;
            end
         end else if (redirect && mem_req) begin
            drain_pend = 1'b1;
         end
         if (redirect) exp_pc = redirect_addr;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int nreq;
      rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
      ack_en = 1'b1; pc_init = 16'h0010;
      step(); step();
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_offset", 32'(pc_offset), 0);
      chk("rst_load", 32'(pc_load), 0);
      chk("rst_data", 32'(pc_data), 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_state", 32'(state_dbg), 32'(IF_IDLE));

      // first fetch, zero-wait memory
      rst = 1'b0;
      step();
      chk("t1_req", 32'(mem_req), 1);
      chk("t1_addr", 32'(mem_addr), 32'h0010);
      chk("t1_state", 32'(state_dbg), 32'(IF_REQ));
      chk("t1_valid0", 32'(instr_valid), 0);
      step();
      chk("t1_valid", 32'(instr_valid), 1);
      chk("t1_instr", 32'(instr), 32'hA5A5);
      chk("t1_ipc", 32'(instr_pc), 32'h0010);
      chk("t1_offset", 32'(pc_offset), 1);
      chk("t1_pcdata", 32'(pc_data), 1);
      chk("t1_req_drop", 32'(mem_req), 0);
      step();
      chk("t1_offset_once", 32'(pc_offset), 0);
      chk("t1_idle", 32'(state_dbg), 32'(IF_IDLE));

      // decoder stalled: only one more entry fits
      nreq = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (mem_req) nreq++;
      end
      chk("t2_fetches", 32'(nreq), 1);
      chk("t2_req_off", 32'(mem_req), 0);
      chk("t2_hold_pc", 32'(instr_pc), 32'h0010);
      chk("t2_hold_instr", 32'(instr), 32'hA5A5);
      instr_ready = 1'b1;
      repeat (8) step();

      // redirect while memory stalls
      ack_en = 1'b0;
      wait_req("t3_wait_req");
      instr_ready = 1'b0;
      redirect = 1'b1; redirect_addr = 16'h0200;
      step();
      redirect = 1'b0;
      chk("t3_load", 32'(pc_load), 1);
      chk("t3_pcdata", 32'(pc_data), 32'h0200);
      chk("t3_no_offset", 32'(pc_offset), 0);
      chk("t3_drain", 32'(state_dbg), 32'(IF_DRAIN));
      chk("t3_req_held", 32'(mem_req), 1);
      chk("t3_flushed", 32'(instr_valid), 0);
      step();
      chk("t3_load_once", 32'(pc_load), 0);
      chk("t3_req_held2", 32'(mem_req), 1);
      step();
      chk("t3_req_held3", 32'(mem_req), 1);
      ack_en = 1'b1;
      step();
      chk("t3_req_drop", 32'(mem_req), 0);
      chk("t3_adv", 32'(state_dbg), 32'(IF_ADV));
      chk("t3_discarded", 32'(instr_valid), 0);
      wait_valid("t3_wait_valid");
      chk("t3_new_pc", 32'(instr_pc), 32'h0200);
      chk("t3_new_instr", 32'(instr), 32'hA7B5);
      repeat (10) step();
      chk("t4_full_idle", 32'(state_dbg), 32'(IF_IDLE));
      chk("t4_full_noreq", 32'(mem_req), 0);

      // redirect with full queue and a pop in the same cycle
      redirect = 1'b1; redirect_addr = 16'h0300; instr_ready = 1'b1;
      step();
      redirect = 1'b0; instr_ready = 1'b0;
      chk("t4_empty", 32'(instr_valid), 0);
      chk("t4_load", 32'(pc_load), 1);
      chk("t4_no_offset", 32'(pc_offset), 0);
      chk("t4_pcdata", 32'(pc_data), 32'h0300);
      chk("t4_adv", 32'(state_dbg), 32'(IF_ADV));
      wait_valid("t4_wait_valid");
      chk("t4_new_pc", 32'(instr_pc), 32'h0300);

      // redirect in REQ with ack in the same cycle
      wait_req("t5_wait_req");
      redirect = 1'b1; redirect_addr = 16'h0400;
      step();
      redirect = 1'b0;
      chk("t5_load", 32'(pc_load), 1);
      chk("t5_pcdata", 32'(pc_data), 32'h0400);
      chk("t5_no_offset", 32'(pc_offset), 0);
      chk("t5_adv", 32'(state_dbg), 32'(IF_ADV));
      chk("t5_req_drop", 32'(mem_req), 0);
      chk("t5_flushed", 32'(instr_valid), 0);
      wait_valid("t5_wait_valid");
      chk("t5_new_pc", 32'(instr_pc), 32'h0400);

      // reset in the middle of a stalled request
      ack_en = 1'b0;
      wait_req("t6_wait_req");
      rst = 1'b1;
      step();
      chk("t6_req", 32'(mem_req), 0);
      chk("t6_addr", 32'(mem_addr), 0);
      chk("t6_state", 32'(state_dbg), 32'(IF_IDLE));
      chk("t6_valid", 32'(instr_valid), 0);
      chk("t6_instr", 32'(instr), 0);
      chk("t6_ipc", 32'(instr_pc), 0);
      chk("t6_load", 32'(pc_load), 0);
      chk("t6_offset", 32'(pc_offset), 0);
      chk("t6_pcdata", 32'(pc_data), 0);
`ifdef IFETCH_STATS_EN
      chk("t6_stat_fetch", 32'(stat_fetch), 0);
      chk("t6_stat_disc", 32'(stat_discard), 0);
`endif
      step();
      rst = 1'b0;

`ifdef IFETCH_STATS_EN
      // three fetches, then one response dropped by a redirect
      ack_en = 1'b1; instr_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (fetch_cnt >= 3) break;
         step();
      end
      ack_en = 1'b0;
      chk("t7_three", 32'(fetch_cnt), 3);
      wait_req("t7_wait_req");
      redirect = 1'b1; redirect_addr = 16'h0500;
      step();
      redirect = 1'b0; ack_en = 1'b1;
      step();
      ack_en = 1'b0;
      step();
      chk("t7_stat_fetch", 32'(stat_fetch), 3);
      chk("t7_stat_disc", 32'(stat_discard), 1);
`endif

      // drain whatever is left; the scoreboard must end empty
      ack_en = 1'b0; instr_ready = 1'b1;
      repeat (4) step();
      chk("sb_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
